// File: rtl/sram_bist_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bist_seq_if
//  Description : Register-level bus between the BIST sequencer and the SRAM
//                controller (command registers out, read data/status back).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_bist_seq_if;
    logic [31:0] enable;
    logic [31:0] send;
    logic [31:0] sta_addr;
    logic [31:0] tim_cfg;
    logic [31:0] op_cfg;
    logic [31:0] outp_data;
    logic [31:0] outp_addr;
    logic [31:0] status;

    modport master (
        output enable, send, sta_addr, tim_cfg, op_cfg,
        input  outp_data, outp_addr, status
    );

    modport slave (
        input  enable, send, sta_addr, tim_cfg, op_cfg,
        output outp_data, outp_addr, status
    );
endinterface
`default_nettype wire

// File: rtl/sram_bist_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bist_seq
//  Description : SRAM self-test sequencer: configures the controller, writes
//                one pattern burst, reads the window back and scores it.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bist_seq #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [1:0]        mode,
    sram_bist_seq_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam int                c_WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST   = c_WD_W'(TIMEOUT - 1);
    localparam logic [7:0]        c_ST_CONFIG = 8'h01;
    localparam logic [7:0]        c_ST_IDLE   = 8'h02;
    localparam logic [7:0]        c_ST_READ   = 8'h04;
    localparam logic [7:0]        c_ST_WRITE  = 8'h08;
    localparam logic [7:0]        c_ST_UPDATE = 8'h10;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CFG   = 4'd1,
        S_ARM   = 4'd2,
        S_WKICK = 4'd3,
        S_WWAIT = 4'd4,
        S_RSET  = 4'd5,
        S_RKICK = 4'd6,
        S_RWAIT = 4'd7,
        S_CMP   = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_pattern;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_length;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_idx;
    logic [c_WD_W-1:0] r_wd;
    logic              r_seen_a;
    logic              r_seen_b;
    logic              r_hold;
    logic [31:0]       r_enable;
    logic [31:0]       r_send;
    logic [31:0]       r_sta_addr;
    logic [31:0]       r_tim_cfg;
    logic [31:0]       r_op_cfg;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic [15:0]       r_err_cnt;
    logic [ADDR_W-1:0] r_first_err;

    logic [ADDR_W-1:0] w_room;
    logic [ADDR_W-1:0] w_last;
    logic [ADDR_W:0]   w_addr_ext;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_st;
    logic              w_wait_state;
    logic              w_wd_hit;
    logic              w_mismatch;
    logic [15:0]       w_err_next;
    logic              w_unused;

    // Beat clamp mirrors the controller: ~base is L-1-base for increment runs.
    assign w_room       = r_mode[1] ? r_base : ~r_base;
    assign w_last       = r_mode[0] ? r_length : ((r_length < w_room) ? r_length : w_room);
    assign w_addr_ext   = r_mode[1] ? ({1'b0, r_base} - {1'b0, r_idx})
                                    : ({1'b0, r_base} + {1'b0, r_idx});
    assign w_addr       = w_addr_ext[ADDR_W-1:0];
    assign w_st         = bus.status[7:0];
    assign w_wait_state = (r_state == S_CFG) || (r_state == S_ARM) ||
                          (r_state == S_WWAIT) || (r_state == S_RWAIT);
    assign w_wd_hit     = w_wait_state && (r_wd == c_WD_LAST);
    assign w_mismatch   = (bus.outp_data[DATA_W-1:0] != r_pattern) ||
                          (bus.outp_addr[ADDR_W-1:0] != w_addr);
    assign w_err_next   = (!w_mismatch || r_err_cnt == 16'hFFFF) ? r_err_cnt
                                                                 : r_err_cnt + 16'd1;
    assign w_unused     = ^{bus.status[31:8], bus.outp_data[31:DATA_W],
                            bus.outp_addr[31:ADDR_W], w_addr_ext[ADDR_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pattern   <= '0;
            r_base      <= '0;
            r_length    <= '0;
            r_mode      <= '0;
            r_idx       <= '0;
            r_wd        <= '0;
            r_seen_a    <= 1'b0;
            r_seen_b    <= 1'b0;
            r_hold      <= 1'b0;
            r_enable    <= '0;
            r_send      <= '0;
            r_sta_addr  <= '0;
            r_tim_cfg   <= '0;
            r_op_cfg    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else begin
            r_done <= 1'b0;
            r_wd   <= r_wd + c_WD_W'(1);
            if (w_wd_hit) begin
                r_enable  <= '0;
                r_timeout <= 1'b1;
                r_pass    <= 1'b0;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_wd      <= '0;
                r_state   <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_pattern   <= pattern;
                            r_base      <= base_addr;
                            r_length    <= length;
                            r_mode      <= mode;
                            r_sta_addr  <= 32'(base_addr);
                            r_tim_cfg   <= 32'(length);
                            r_op_cfg    <= {30'b0, mode};
                            r_pass      <= 1'b0;
                            r_timeout   <= 1'b0;
                            r_err_cnt   <= '0;
                            r_first_err <= '0;
                            r_busy      <= 1'b1;
                            r_seen_a    <= 1'b0;
                            r_hold      <= 1'b0;
                            r_wd        <= '0;
                            r_state     <= S_CFG;
                        end
                    end
                    S_CFG: begin
                        if (!r_seen_a) begin
                            r_seen_a <= (w_st == c_ST_CONFIG);
                        end else if (r_hold) begin
                            r_enable <= 32'h1;
                            r_wd     <= '0;
                            r_state  <= S_ARM;
                        end else begin
                            r_hold <= 1'b1;
                        end
                    end
                    S_ARM: begin
                        if (w_st == c_ST_IDLE) begin
                            r_wd    <= '0;
                            r_state <= S_WKICK;
                        end
                    end
                    S_WKICK: begin
                        // Toggling bit 31 guarantees the controller sees a new command.
                        r_send   <= {~r_send[31], 31'(r_pattern)};
                        r_seen_a <= 1'b0;
                        r_seen_b <= 1'b0;
                        r_wd     <= '0;
                        r_state  <= S_WWAIT;
                    end
                    S_WWAIT: begin
                        if (!r_seen_a) begin
                            r_seen_a <= (w_st == c_ST_WRITE);
                        end else if (!r_seen_b) begin
                            r_seen_b <= (w_st == c_ST_UPDATE);
                        end else if (w_st == c_ST_IDLE) begin
                            r_enable <= 32'h3;
                            r_idx    <= '0;
                            r_hold   <= 1'b0;
                            r_wd     <= '0;
                            r_state  <= S_RSET;
                        end
                    end
                    S_RSET: begin
                        if (r_hold) begin
                            r_wd    <= '0;
                            r_state <= S_RKICK;
                        end else begin
                            r_hold <= 1'b1;
                        end
                    end
                    S_RKICK: begin
                        r_send   <= {~r_send[31], 31'(w_addr)};
                        r_seen_a <= 1'b0;
                        r_wd     <= '0;
                        r_state  <= S_RWAIT;
                    end
                    S_RWAIT: begin
                        if (!r_seen_a) begin
                            r_seen_a <= (w_st == c_ST_READ);
                        end else if (w_st == c_ST_IDLE) begin
                            r_wd    <= '0;
                            r_state <= S_CMP;
                        end
                    end
                    S_CMP: begin
                        r_err_cnt <= w_err_next;
                        if (w_mismatch && r_err_cnt == 16'd0) begin
                            r_first_err <= w_addr;
                        end
                        r_wd <= '0;
                        if (r_idx == w_last) begin
                            r_enable <= '0;
                            r_pass   <= (w_err_next == 16'd0) && !r_timeout;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + ADDR_W'(1);
                            r_state <= S_RKICK;
                        end
                    end
                    S_DONE: begin
                        r_wd    <= '0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_enable <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.enable     = r_enable;
    assign bus.send       = r_send;
    assign bus.sta_addr   = r_sta_addr;
    assign bus.tim_cfg    = r_tim_cfg;
    assign bus.op_cfg     = r_op_cfg;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err;
endmodule
`default_nettype wire

// File: tb/tb_sram_bist_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bist_seq
//  Description : Directed bench for sram_bist_seq with a behavioural SRAM
//                controller model on the register bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bist_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pattern = '0;
    logic [9:0]  base_addr = '0;
    logic [9:0]  length = '0;
    logic [1:0]  mode = '0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt;
    logic [9:0]  first_err_addr;

    sram_bist_seq_if bus ();

    sram_bist_seq #(.ADDR_W(10), .DATA_W(8), .TIMEOUT(4096)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .pattern        (pattern),
        .base_addr      (base_addr),
        .length         (length),
        .mode           (mode),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    // Controller model: 0=CONFIG 1=IDLE 2=WRITE 3=UPDATE 4=READ
    int         m_st;
    logic [31:0] m_prev;
    logic [9:0] m_base, m_len, m_waddr, m_left;
    logic [1:0] m_mode;
    logic [7:0] m_wdata;
    logic [7:0] mem [0:1023];
    logic [9:0] rd_log [$];
    bit         hold_write = 1'b0;
    bit         corrupt [0:1023];

    function automatic logic [9:0] clamp_last(input logic [9:0] b, input logic [9:0] l,
                                              input logic [1:0] m);
        int room;
        if (m[0]) return l;
        room = m[1] ? int'(b) : 1023 - int'(b);
        return (int'(l) < room) ? l : 10'(room);
    endfunction

    always @(posedge clk) begin
        m_prev <= bus.send;
        if (reset || !bus.enable[0]) begin
            m_st       <= 0;
            bus.status <= 32'h1;
            if (reset) begin
                bus.outp_data <= '0;
                bus.outp_addr <= '0;
            end
        end else begin
            case (m_st)
                0: begin
                    m_base     <= bus.sta_addr[9:0];
                    m_len      <= bus.tim_cfg[9:0];
                    m_mode     <= bus.op_cfg[1:0];
                    m_st       <= 1;
                    bus.status <= 32'h2;
                end
                1: if (bus.send !== m_prev) begin
                    if (!bus.enable[1]) begin
                        m_waddr    <= m_base;
                        m_left     <= clamp_last(m_base, m_len, m_mode);
                        m_wdata    <= bus.send[7:0];
                        m_st       <= 2;
                        bus.status <= 32'h8;
                    end else begin
                        bus.outp_data <= {24'h0, mem[bus.send[9:0]]};
                        bus.outp_addr <= {22'h0, bus.send[9:0]};
                        rd_log.push_back(bus.send[9:0]);
                        m_st       <= 4;
                        bus.status <= 32'h4;
                    end
                end
                2: if (!hold_write) begin
                    mem[m_waddr] <= corrupt[m_waddr] ? 8'h00 : m_wdata;
                    if (m_left == 10'd0) begin
                        m_st       <= 3;
                        bus.status <= 32'h10;
                    end else begin
                        m_left  <= m_left - 10'd1;
                        m_waddr <= m_mode[1] ? m_waddr - 10'd1 : m_waddr + 10'd1;
                    end
                end
                default: begin
                    m_st       <= 1;
                    bus.status <= 32'h2;
                end
            endcase
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int rd0;
    int cyc;
    bit ok;

    task automatic run_start(input logic [9:0] b, input logic [9:0] l,
                             input logic [1:0] m, input logic [7:0] p);
        @(negedge clk);
        base_addr = b; length = l; mode = m; pattern = p;
        start = 1'b1;
        rd0 = rd_log.size();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (n < budget) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, pass, timeout, err_cnt, first_err_addr} !== 30'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, pass, timeout, err_cnt, first_err_addr});
        end
        n_cmp++;
        if ({bus.enable, bus.send, bus.sta_addr, bus.tim_cfg, bus.op_cfg} !== 160'h0) begin
            n_bad++;
            $display("FAIL reset_bus: enable=%h send=%h sta=%h tim=%h op=%h want all 0",
                     bus.enable, bus.send, bus.sta_addr, bus.tim_cfg, bus.op_cfg);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, bus.enable} !== 33'h0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b enable=%h want 0/0", busy, bus.enable);
        end
    endtask

    task automatic test_basic;
        run_start(10'h010, 10'h00F, 2'b00, 8'hA5);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_done(2000, cyc, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++; $display("FAIL basic_done: no done after %0d cycles", cyc);
        end
        n_cmp++;
        if ({pass, timeout, err_cnt} !== {1'b1, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL basic_result: pass=%b timeout=%b err=%h want 1/0/0", pass, timeout, err_cnt);
        end
        n_cmp++;
        if (rd_log.size() - rd0 !== 16) begin
            n_bad++; $display("FAIL basic_nreads: got %0d want 16", rd_log.size() - rd0);
        end
        for (int i = 0; i < 16; i++) begin
            if (rd0 + i < rd_log.size()) begin
                n_cmp++;
                if (rd_log[rd0 + i] !== 10'(16 + i)) begin
                    n_bad++;
                    $display("FAIL basic_addr[%0d]: got %h want %h", i, rd_log[rd0 + i], 10'(16 + i));
                end
            end
        end
        n_cmp++;
        if ({bus.sta_addr, bus.tim_cfg, bus.op_cfg} !== {32'h10, 32'hF, 32'h0}) begin
            n_bad++;
            $display("FAIL basic_cfg: sta=%h tim=%h op=%h want 10/f/0",
                     bus.sta_addr, bus.tim_cfg, bus.op_cfg);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy, bus.enable} !== 34'h0) begin
            n_bad++;
            $display("FAIL basic_after: done=%b busy=%b enable=%h want 0/0/0", done, busy, bus.enable);
        end
    endtask

    task automatic test_dec_clamp;
        run_start(10'h005, 10'h3FF, 2'b10, 8'h5A);
        wait_done(2000, cyc, ok);
        n_cmp++;
        if (ok !== 1'b1 || pass !== 1'b1) begin
            n_bad++; $display("FAIL dec_result: done=%b pass=%b want 1/1", ok, pass);
        end
        n_cmp++;
        if (rd_log.size() - rd0 !== 6) begin
            n_bad++; $display("FAIL dec_nreads: got %0d want 6", rd_log.size() - rd0);
        end
        for (int i = 0; i < 6; i++) begin
            if (rd0 + i < rd_log.size()) begin
                n_cmp++;
                if (rd_log[rd0 + i] !== 10'(5 - i)) begin
                    n_bad++;
                    $display("FAIL dec_addr[%0d]: got %h want %h", i, rd_log[rd0 + i], 10'(5 - i));
                end
            end
        end
    endtask

    task automatic test_wrap;
        logic [9:0] exp_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        run_start(10'h3FE, 10'h003, 2'b01, 8'h3C);
        wait_done(2000, cyc, ok);
        n_cmp++;
        if (ok !== 1'b1 || pass !== 1'b1) begin
            n_bad++; $display("FAIL wrap_result: done=%b pass=%b want 1/1", ok, pass);
        end
        n_cmp++;
        if (rd_log.size() - rd0 !== 4) begin
            n_bad++; $display("FAIL wrap_nreads: got %0d want 4", rd_log.size() - rd0);
        end
        for (int i = 0; i < 4; i++) begin
            if (rd0 + i < rd_log.size()) begin
                n_cmp++;
                if (rd_log[rd0 + i] !== exp_a[i]) begin
                    n_bad++;
                    $display("FAIL wrap_addr[%0d]: got %h want %h", i, rd_log[rd0 + i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_fault;
        corrupt[10'h012] = 1'b1;
        run_start(10'h010, 10'h00F, 2'b00, 8'hA5);
        wait_done(2000, cyc, ok);
        n_cmp++;
        if ({ok, pass, timeout, err_cnt, first_err_addr} !== {1'b1, 1'b0, 1'b0, 16'd1, 10'h012}) begin
            n_bad++;
            $display("FAIL fault_single: done=%b pass=%b to=%b err=%h first=%h want 1/0/0/1/012",
                     ok, pass, timeout, err_cnt, first_err_addr);
        end
        corrupt[10'h015] = 1'b1;
        run_start(10'h010, 10'h00F, 2'b00, 8'hC3);
        wait_done(2000, cyc, ok);
        n_cmp++;
        if ({ok, pass, err_cnt, first_err_addr} !== {1'b1, 1'b0, 16'd2, 10'h012}) begin
            n_bad++;
            $display("FAIL fault_double: done=%b pass=%b err=%h first=%h want 1/0/2/012",
                     ok, pass, err_cnt, first_err_addr);
        end
        corrupt[10'h012] = 1'b0;
        corrupt[10'h015] = 1'b0;
    endtask

    task automatic test_busy_start;
        run_start(10'h010, 10'h00F, 2'b00, 8'h11);
        n_cmp++;
        if ({pass, err_cnt, first_err_addr} !== 27'h0) begin
            n_bad++;
            $display("FAIL start_clear: pass=%b err=%h first=%h want 0/0/0", pass, err_cnt, first_err_addr);
        end
        repeat (5) @(negedge clk);
        base_addr = 10'h100; length = 10'h000; pattern = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (bus.sta_addr !== 32'h10) begin
            n_bad++; $display("FAIL busy_start_cfg: sta=%h want 10", bus.sta_addr);
        end
        wait_done(2000, cyc, ok);
        n_cmp++;
        if (ok !== 1'b1 || pass !== 1'b1 || rd_log.size() - rd0 !== 16) begin
            n_bad++;
            $display("FAIL busy_start_run: done=%b pass=%b reads=%0d want 1/1/16",
                     ok, pass, rd_log.size() - rd0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL done_start: busy=%b want 0", busy);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pass !== 1'b1 || bus.sta_addr !== 32'h10) begin
            n_bad++; $display("FAIL pass_hold: pass=%b sta=%h want 1/10", pass, bus.sta_addr);
        end
    endtask

    task automatic test_watchdog;
        logic [31:0] s0;
        hold_write = 1'b1;
        run_start(10'h010, 10'h00F, 2'b00, 8'h99);
        s0 = bus.send;
        cyc = 0;
        while (bus.send === s0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (bus.send === s0) begin
            n_bad++; $display("FAIL wd_kick: send=%h never changed", bus.send);
        end
        wait_done(6000, cyc, ok);
        n_cmp++;
        if (ok !== 1'b1 || cyc !== 4096) begin
            n_bad++; $display("FAIL wd_latency: done=%b after %0d cycles want 4096", ok, cyc);
        end
        n_cmp++;
        if ({timeout, pass} !== 2'b10) begin
            n_bad++; $display("FAIL wd_flags: timeout=%b pass=%b want 1/0", timeout, pass);
        end
        @(negedge clk);
        hold_write = 1'b0;
        n_cmp++;
        if (bus.enable !== 32'h0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL wd_after: enable=%h busy=%b want 0/0", bus.enable, busy);
        end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] s0;
        bit found;
        run_start(10'h010, 10'h00F, 2'b00, 8'h77);
        found = 1'b0;
        s0 = bus.send;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            if (bus.enable === 32'h3 && bus.send !== s0) found = 1'b1;
            s0 = bus.send;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL rst_find_rwait: no read kick seen, enable=%h", bus.enable);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, pass, timeout, err_cnt, first_err_addr,
             bus.enable, bus.send, bus.sta_addr, bus.tim_cfg, bus.op_cfg} !== 190'h0) begin
            n_bad++;
            $display("FAIL rst_midrun: busy=%b enable=%h send=%h sta=%h tim=%h op=%h want all 0",
                     busy, bus.enable, bus.send, bus.sta_addr, bus.tim_cfg, bus.op_cfg);
        end
        reset = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++;
        if ({busy, done, bus.enable} !== 34'h0) begin
            n_bad++;
            $display("FAIL rst_abandon: busy=%b done=%b enable=%h want 0", busy, done, bus.enable);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dec_clamp();
        test_wrap();
        test_fault();
        test_busy_start();
        test_watchdog();
        test_reset_midrun();
        test_basic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: bench did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/sram_bist_seq.md
# sram_bist_seq

Self-test sequencer that sits directly upstream of the SRAM controller and drives its 32-bit bus-side register inputs in place of the AXI register bank. On `start` it configures the controller, issues one pattern write burst over an address window, then reads back every address in that window one at a time. Each read is compared against the expected pattern, and the sequencer reports pass/fail, an error count and the first failing address.

## Interface
- `ADDR_W`, 10, SRAM address width; depth `L = 2**ADDR_W`.
- `DATA_W`, 8, SRAM data width.
- `TIMEOUT`, 4096, maximum cycles spent in any wait state before the run aborts.
- `clk`  in  1  single clock, shared with the controller.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; ignored while `busy`.
- `pattern`  in  DATA_W  write and expected data.
- `base_addr`  in  ADDR_W  window start address.
- `length`  in  ADDR_W  beat count minus 1 (0 means 1 beat).
- `mode`  in  2  `[1]` 0=increment, 1=decrement; `[0]` 1=wrap mod L.
- `enable`, `send`, `sta_addr`, `tim_cfg`, `op_cfg`  out  32 each  to the controller.
- `outp_data`, `outp_addr`, `status`  in  32 each  from the controller.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  result of the last run; held until the next `start`.
- `timeout`  out  1  the last run aborted on the watchdog.
- `err_cnt`  out  16  read mismatches in the last run; saturates at 0xFFFF.
- `first_err_addr`  out  ADDR_W  address of the first mismatch.

## Operation
- Controller status encoding: `status[7:0]` is one-hot: CONFIG=0x01, IDLE=0x02, READ=0x04, WRITE=0x08, UPDATE=0x10. Bits 9 and 10 are overflow flags, which the sequencer ignores.
- Controller command fields:
  - `enable[0]` is ena.
  - `enable[1]` is cmd: 0=write, 1=read.
  - The controller acts on any change of `send` while it is in IDLE.
  - `send[DATA_W-1:0]` carries write data; `send[ADDR_W-1:0]` carries the read address.
  - The sequencer toggles `send[31]` on every kick so that `send` always changes.
- Effective beat count N-1, matching the controller's clamp:
  - increment, no wrap: min(length, L-1-base_addr);
  - decrement, no wrap: min(length, base_addr);
  - wrap: length.
- Beat address: `a_i = base_addr ± i` mod L.
- States:
  - S_IDLE: `enable=0`. On `start`, latch all inputs, clear the result outputs, set `busy`, go to S_CFG.
  - S_CFG: drive `enable=0`, `sta_addr=base_addr`, `tim_cfg=length`, `op_cfg={30'b0,mode}`. Wait for status==CONFIG, then hold 2 more cycles and go to S_ARM.
  - S_ARM: drive `enable=32'h1` (write). Wait for status==IDLE, then go to S_WKICK.
  - S_WKICK: drive `send={~send[31], 23'b0, pattern}` for one cycle, then go to S_WWAIT.
  - S_WWAIT: wait until WRITE has been seen, then UPDATE, then IDLE. Set `i=0` and go to S_RSET.
  - S_RSET: drive `enable=32'h3` (read) for 2 cycles, with `send` unchanged. Go to S_RKICK.
  - S_RKICK: drive `send={~send[31], 21'b0, a_i}`, then go to S_RWAIT.
  - S_RWAIT: wait until READ has been seen, then IDLE, then go to S_CMP.
  - S_CMP: a mismatch is `outp_data[DATA_W-1:0]!=pattern` or `outp_addr[ADDR_W-1:0]!=a_i`.
    - On a mismatch, increment `err_cnt`. If this is the first mismatch, record `first_err_addr=a_i`.
    - If `i==N-1`, go to S_DONE. Otherwise increment `i` and go to S_RKICK.
  - S_DONE: drive `enable=0`, pulse `done`, set `pass = (err_cnt==0 && !timeout)`, clear `busy`, go to S_IDLE.
- Watchdog:
  - The watchdog counter clears on every state entry.
  - In S_CFG, S_ARM, S_WWAIT and S_RWAIT, reaching TIMEOUT sets `timeout=1` and jumps to S_DONE.

## Timing
- Reset values: every output is 0, `send[31]=0`, state is S_IDLE.
- Reset mid-run: the run abandons immediately. `enable=0` forces the controller back to CONFIG.
- All outputs are registered. The `start`→`busy` latency is 1 cycle.
- Status-driven transitions are taken the cycle after the matching `status` value is sampled.
- `outp_data` and `outp_addr` are sampled in S_CMP, at least 1 cycle after status returns to IDLE.
- A `start` that arrives while `busy` is dropped. A `start` in the same cycle as `done` is also dropped.
- `err_cnt` saturates at 0xFFFF. `first_err_addr` is not updated after the first mismatch.
- Address arithmetic is done at ADDR_W+1 bits and truncated mod L.

## Test plan
- Basic run: base=0x010, length=0x00F, mode=00, pattern=0xA5. Required: 16 reads of addresses 0x010..0x01F, `done` pulses, `pass=1`, `err_cnt=0`.
- Decrement clamp: base=0x005, length=0x3FF, mode=10. Required: N=6, reads of 0x005 down to 0x000, `pass=1`.
- Wrap: base=0x3FE, length=0x003, mode=01, pattern=0x3C. Required: reads of 0x3FE, 0x3FF, 0x000, 0x001, `pass=1`.
- Fault injection: corrupt SRAM address 0x012 to 0x00 in the basic run. Required: `err_cnt=1`, `first_err_addr=0x012`, `pass=0`.
- Watchdog: hold `status` at 0x08 (WRITE) indefinitely. Required: `timeout=1`, `pass=0`, `done` pulses 4096 cycles after S_WWAIT entry, `enable=0` afterwards.
- Reset and busy handling:
  - Assert `reset` during S_RWAIT. Required: all outputs return to 0 the next cycle.
  - Pulse `start` while `busy`. Required: the pulse is ignored.
